// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared constants and types for the equalizer gain sequencer.
//            EQ_* constants are the default values of the sequencer
//            parameters.
// Contents : EQ_NBAND, EQ_GW, EQ_GAIN_MAX, EQ_GAIN_MIN, EQ_STEP,
//            gain_t, band_t, state_t
// Revision : 1.0 - initial release
// ============================================================================
package eq_pkg;

  localparam int EQ_NBAND    = 6;    // highest band index (bands 0..EQ_NBAND)
  localparam int EQ_GW       = 16;   // gain word width, signed dB
  localparam int EQ_GAIN_MAX = 12;   // target clamp upper bound (dB)
  localparam int EQ_GAIN_MIN = -12;  // target clamp lower bound (dB)
  localparam int EQ_STEP     = 1;    // ramp step per band per frame (dB)

  typedef logic signed [EQ_GW-1:0] gain_t;
  typedef logic [2:0]              band_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage : eq_pkg
`default_nettype wire

// File: rtl/eq_gain_step.sv
`default_nettype none
// ============================================================================
// Module   : eq_gain_step
// Purpose  : Combinational next-applied-gain computation step(a, t).
//            With GAIN_RAMP_EN defined the applied gain moves STEP dB toward
//            the target and never overshoots it; otherwise the target is
//            returned directly and STEP is unused.
// Macro    : GAIN_RAMP_EN (optional ramping)
// Ports    : i_app  - current applied gain (signed)
//            i_tgt  - target gain (signed)
//            o_next - next applied gain (signed)
// Revision : 1.0 - initial release
// ============================================================================
module eq_gain_step #(
  parameter int GW   = 16,
  parameter int STEP = 1
) (
  input  logic signed [GW-1:0] i_app,
  input  logic signed [GW-1:0] i_tgt,
  output logic signed [GW-1:0] o_next
);

`ifdef GAIN_RAMP_EN
  // One extra bit of headroom so a+STEP / a-STEP cannot wrap.
  logic signed [GW:0] w_app;
  logic signed [GW:0] w_tgt;
  logic signed [GW:0] w_up;
  logic signed [GW:0] w_dn;

  assign w_app = {i_app[GW-1], i_app};
  assign w_tgt = {i_tgt[GW-1], i_tgt};
  assign w_up  = w_app + (GW+1)'(STEP);
  assign w_dn  = w_app - (GW+1)'(STEP);

  always_comb begin
    o_next = i_app;
    if (w_tgt > w_app) begin
      o_next = (w_up > w_tgt) ? i_tgt : w_up[GW-1:0];
    end else if (w_tgt < w_app) begin
      o_next = (w_dn < w_tgt) ? i_tgt : w_dn[GW-1:0];
    end
  end
`else
  // Direct jump to the target; the applied value and STEP play no part.
  logic w_unused;
  assign w_unused = (^i_app) ^ (STEP != 0);

  always_comb begin
    o_next = i_tgt;
  end
`endif

endmodule : eq_gain_step
`default_nettype wire

// File: rtl/eq_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : eq_gain_sequencer
// Purpose  : Holds per-band target and applied equalizer gains. Accepts
//            clamped gain requests at any time and, on each frame strobe,
//            walks bands 0..NBAND issuing one coefficient write for every
//            band whose applied gain differs from its target.
// Macro    : GAIN_RAMP_EN - ramp applied gains by STEP dB per frame
//            (default: jump straight to the target)
// Ports    : i_clk, i_rst          - clock, synchronous active-high reset
//            i_set_valid/band/gain - gain request (always accepted)
//            o_set_err             - pulse: request band out of range
//            i_frame               - frame strobe
//            o_coef_valid/band/gain, i_coef_ready - coefficient write port
//            o_busy                - sequencer not idle
//            o_overrun             - pulse: frame strobe dropped
// Revision : 1.0 - initial release
// ============================================================================
module eq_gain_sequencer
  import eq_pkg::*;
#(
  parameter int NBAND    = EQ_NBAND,
  parameter int GW       = EQ_GW,
  parameter int GAIN_MAX = EQ_GAIN_MAX,
  parameter int GAIN_MIN = EQ_GAIN_MIN,
  parameter int STEP     = EQ_STEP
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_valid,
  input  logic [2:0]           i_set_band,
  input  logic signed [GW-1:0] i_set_gain,
  output logic                 o_set_err,
  input  logic                 i_frame,
  output logic                 o_coef_valid,
  output logic [2:0]           o_coef_band,
  output logic signed [GW-1:0] o_coef_gain,
  input  logic                 i_coef_ready,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam band_t              c_nband    = band_t'(NBAND);
  localparam logic signed [GW-1:0] c_gain_max = GW'(GAIN_MAX);
  localparam logic signed [GW-1:0] c_gain_min = GW'(GAIN_MIN);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,      state_d;
  band_t               idx_q,        idx_d;
  logic                pending_q,    pending_d;
  logic signed [GW-1:0] tgt_q [0:NBAND];
  logic signed [GW-1:0] tgt_d [0:NBAND];
  logic signed [GW-1:0] app_q [0:NBAND];
  logic signed [GW-1:0] app_d [0:NBAND];
  logic                coef_valid_q, coef_valid_d;
  band_t               coef_band_q,  coef_band_d;
  logic signed [GW-1:0] coef_gain_q, coef_gain_d;
  logic                set_err_q,    set_err_d;
  logic                overrun_q,    overrun_d;

  // --------------------------------------------------------------------------
  // Request clamp and step computation
  // --------------------------------------------------------------------------
  logic                 w_set_ok;
  logic signed [GW-1:0] w_set_clamped;
  logic signed [GW-1:0] w_cur_app;
  logic signed [GW-1:0] w_cur_tgt;
  logic signed [GW-1:0] w_step_next;

  assign w_set_ok  = i_set_valid && (i_set_band <= c_nband);
  assign w_cur_app = app_q[idx_q];
  assign w_cur_tgt = tgt_q[idx_q];

  always_comb begin
    w_set_clamped = i_set_gain;
    if (i_set_gain > c_gain_max) begin
      w_set_clamped = c_gain_max;
    end else if (i_set_gain < c_gain_min) begin
      w_set_clamped = c_gain_min;
    end
  end

  eq_gain_step #(
    .GW   (GW),
    .STEP (STEP)
  ) u_step (
    .i_app  (w_cur_app),
    .i_tgt  (w_cur_tgt),
    .o_next (w_step_next)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    tgt_d        = tgt_q;
    app_d        = app_q;
    coef_valid_d = coef_valid_q;
    coef_band_d  = coef_band_q;
    coef_gain_d  = coef_gain_q;
    set_err_d    = 1'b0;
    overrun_d    = 1'b0;

    // The set path is independent of the FSM: a target written in the same
    // cycle as the frame strobe is visible to the scan that follows.
    if (w_set_ok) begin
      tgt_d[i_set_band] = w_set_clamped;
    end else if (i_set_valid) begin
      set_err_d = 1'b1;
    end

    // A frame arriving mid-sequence is remembered once; a second one while
    // a rescan is already queued is lost and flagged.
    if (i_frame && (state_q != S_IDLE)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_frame || pending_q) begin
          pending_d = 1'b0;
          idx_d     = '0;
          state_d   = S_SCAN;
        end
      end

      S_SCAN: begin
        if (w_cur_app != w_cur_tgt) begin
          // The write value is frozen here; a target change during the
          // write is picked up on the next frame.
          coef_valid_d = 1'b1;
          coef_band_d  = idx_q;
          coef_gain_d  = w_step_next;
          state_d      = S_WRITE;
        end else if (idx_q == c_nband) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      S_WRITE: begin
        if (i_coef_ready) begin
          app_d[idx_q] = coef_gain_q;
          coef_valid_d = 1'b0;
          if (idx_q == c_nband) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SCAN;
          end
        end
      end

      default: begin
        coef_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      coef_valid_q <= 1'b0;
      coef_band_q  <= '0;
      coef_gain_q  <= '0;
      set_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      for (int b = 0; b <= NBAND; b++) begin
        tgt_q[b] <= '0;
        app_q[b] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      coef_valid_q <= coef_valid_d;
      coef_band_q  <= coef_band_d;
      coef_gain_q  <= coef_gain_d;
      set_err_q    <= set_err_d;
      overrun_q    <= overrun_d;
      tgt_q        <= tgt_d;
      app_q        <= app_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_coef_valid = coef_valid_q;
  assign o_coef_band  = coef_band_q;
  assign o_coef_gain  = coef_gain_q;
  assign o_set_err    = set_err_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule : eq_gain_sequencer
`default_nettype wire

// File: tb/tb_eq_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq_gain_sequencer
// Purpose  : Self-checking bench for eq_gain_sequencer. A transaction-level
//            model (target/applied arrays, expected write queue per frame)
//            predicts every coefficient write; randomized requests, frame
//            options and ready patterns are checked against it.
// Macro    : GAIN_RAMP_EN selects the ramping step rule in the model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eq_gain_sequencer;
  import eq_pkg::*;

  localparam int NB = EQ_NBAND;
  localparam int GW = EQ_GW;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_set_valid;
  logic [2:0]           i_set_band;
  logic signed [GW-1:0] i_set_gain;
  logic                 o_set_err;
  logic                 i_frame;
  logic                 o_coef_valid;
  logic [2:0]           o_coef_band;
  logic signed [GW-1:0] o_coef_gain;
  logic                 i_coef_ready;
  logic                 o_busy;
  logic                 o_overrun;

  always #5 clk = ~clk;

  eq_gain_sequencer dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_set_valid  (i_set_valid),
    .i_set_band   (i_set_band),
    .i_set_gain   (i_set_gain),
    .o_set_err    (o_set_err),
    .i_frame      (i_frame),
    .o_coef_valid (o_coef_valid),
    .o_coef_band  (o_coef_band),
    .o_coef_gain  (o_coef_gain),
    .i_coef_ready (i_coef_ready),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  // --------------------------------------------------------------------------
  // Reference model and bookkeeping
  // --------------------------------------------------------------------------
  typedef struct {int band; int gain;} wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_tgt [0:NB];
  int  m_app [0:NB];
  wr_t obs[$];
  wr_t exp_q[$];
  bit  rand_ready = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clamp(input int g);
    if (g > EQ_GAIN_MAX) return EQ_GAIN_MAX;
    if (g < EQ_GAIN_MIN) return EQ_GAIN_MIN;
    return g;
  endfunction

  function automatic int step_model(input int a, input int t);
`ifdef GAIN_RAMP_EN
    if (t > a) return (a + EQ_STEP > t) ? t : a + EQ_STEP;
    if (t < a) return (a - EQ_STEP < t) ? t : a - EQ_STEP;
    return a;
`else
    return t;
`endif
  endfunction

  // One full pass over the bands: every differing band gets one write.
  task automatic model_scan();
    for (int b = 0; b <= NB; b++) begin
      if (m_app[b] != m_tgt[b]) begin
        int n;
        n = step_model(m_app[b], m_tgt[b]);
        exp_q.push_back('{b, n});
        m_app[b] = n;
      end
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b <= NB; b++) begin
      m_tgt[b] = 0;
      m_app[b] = 0;
    end
  endtask

  // Handshakes observed mid-cycle, where valid/ready are the values the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (o_coef_valid && i_coef_ready) begin
      obs.push_back('{int'(o_coef_band), int'(o_coef_gain)});
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      i_coef_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int b, input int g);
    i_set_valid = 1'b1;
    i_set_band  = b[2:0];
    i_set_gain  = GW'(g);
    tick();
    i_set_valid = 1'b0;
    check("set_err", int'(o_set_err), int'(b > NB));
    if (b <= NB) m_tgt[b] = clamp(g);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, obs.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        check({tag, "_band"}, obs[i].band, exp_q[i].band);
        check({tag, "_gain"}, obs[i].gain, exp_q[i].gain);
      end
    end
  endtask

  // Pulse a frame (optionally with a request in the same cycle) and check
  // the writes of the resulting scan.
  task automatic run_frame(input bit ready_one, input int sb, input int sg);
    int cyc;
    obs.delete();
    exp_q.delete();
    if (ready_one) begin
      rand_ready   = 1'b0;
      i_coef_ready = 1'b1;
    end else begin
      rand_ready = 1'b1;
    end
    if (sb >= 0) begin
      i_set_valid = 1'b1;
      i_set_band  = sb[2:0];
      i_set_gain  = GW'(sg);
      if (sb <= NB) m_tgt[sb] = clamp(sg);
    end
    model_scan();
    i_frame = 1'b1;
    tick();
    i_frame     = 1'b0;
    i_set_valid = 1'b0;
    if (sb >= 0) check("frame_set_err", int'(o_set_err), int'(sb > NB));
    cyc = 0;
    while (o_busy && cyc < 500) begin
      cyc++;
      tick();
    end
    check("scan_done", int'(cyc < 500), 1);
    if (ready_one) check("scan_cycles", cyc, NB + 1 + exp_q.size());
    compare_writes("frame");
    rand_ready   = 1'b0;
    i_coef_ready = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int idle_run;
    int v;

    i_rst        = 1'b1;
    i_set_valid  = 1'b0;
    i_set_band   = '0;
    i_set_gain   = '0;
    i_frame      = 1'b0;
    i_coef_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    i_rst = 1'b0;

    check("rst_busy",  int'(o_busy), 0);
    check("rst_valid", int'(o_coef_valid), 0);
    check("rst_band",  int'(o_coef_band), 0);
    check("rst_gain",  int'(o_coef_gain), 0);
    check("rst_err",   int'(o_set_err), 0);
    check("rst_ovr",   int'(o_overrun), 0);

    // All targets zero: a bare scan of NB+1 cycles, no writes.
    run_frame(1'b1, -1, 0);

    // Single band, observed over enough frames to settle either way.
    do_set(3, 5);
    repeat (6) run_frame(1'b1, -1, 0);

    // Clamping and an out-of-range band.
    do_set(2, 40);
    do_set(1, -99);
    do_set(7, 8);
    tick();
    check("set_err_clear", int'(o_set_err), 0);
    repeat (13) run_frame(1'b1, -1, 0);

    // First and last band in one frame.
    do_set(0, -3);
    do_set(6, -3);
    run_frame(1'b1, -1, 0);

    // Request in the same cycle as the frame.
    run_frame(1'b1, 4, 9);
    run_frame(1'b1, 7, 3);

    // Randomized requests, frame-time requests and ready patterns.
    for (int it = 0; it < 25; it++) begin
      int nset;
      int sb;
      nset = $urandom_range(0, 2);
      for (int k = 0; k < nset; k++) begin
        do_set($urandom_range(0, 7), int'($urandom_range(0, 80)) - 40);
      end
      sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_frame(bit'($urandom_range(0, 1)), sb,
                int'($urandom_range(0, 80)) - 40);
    end

    // Stalled write: outputs held, pending rescan, overrun on second frame.
    v = (m_app[0] == 7) ? -7 : 7;
    do_set(0, v);
    obs.delete();
    exp_q.delete();
    rand_ready   = 1'b0;
    i_coef_ready = 1'b0;
    model_scan();
    model_scan();
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    cyc = 0;
    while (!o_coef_valid && cyc < 50) begin
      cyc++;
      tick();
    end
    check("stall_valid_seen", int'(o_coef_valid), 1);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", int'(o_coef_valid), 1);
      check("stall_band",  int'(o_coef_band), exp_q[0].band);
      check("stall_gain",  int'(o_coef_gain), exp_q[0].gain);
      tick();
    end
    i_frame = 1'b1;
    tick();
    check("overrun_first", int'(o_overrun), 0);
    tick();
    i_frame = 1'b0;
    check("overrun_second", int'(o_overrun), 1);
    tick();
    check("overrun_clear", int'(o_overrun), 0);
    check("stall_hold_gain", int'(o_coef_gain), exp_q[0].gain);
    i_coef_ready = 1'b1;
    cyc      = 0;
    idle_run = 0;
    while (idle_run < 3 && cyc < 500) begin
      tick();
      cyc++;
      idle_run = o_busy ? 0 : idle_run + 1;
    end
    check("rescan_done", int'(cyc < 500), 1);
    compare_writes("rescan");

    // Reset during a stalled write.
    v = (m_app[5] == 7) ? -7 : 7;
    do_set(5, v);
    i_coef_ready = 1'b0;
    i_frame      = 1'b1;
    tick();
    i_frame = 1'b0;
    cyc = 0;
    while (!o_coef_valid && cyc < 50) begin
      cyc++;
      tick();
    end
    check("prerst_valid", int'(o_coef_valid), 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst_valid", int'(o_coef_valid), 0);
    check("midrst_busy",  int'(o_busy), 0);
    check("midrst_gain",  int'(o_coef_gain), 0);
    model_reset();
    run_frame(1'b1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_eq_gain_sequencer
`default_nettype wire
